pyrxaclpack: RTL and testbench

//  Receive-side ACL payload packer. Sits directly upstream of the RX ACL ping-pong payload buffer.
//  - Takes the decoded (de-whitened, FEC-corrected) serial payload bit stream.
//  - Packs the bits LSB-first into 32-bit words.
//  - Writes each word into the active buffer bank through the link-controller write port (addr/din/we/cs).
//  - Counts words and flags payload completion.

---
 rtl/pyrxaclpack.sv | 164 ++++++++++++++++
 tb/tb_pyrxaclpack.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pyrxaclpack.sv
// Receive-side ACL payload packer: gathers the decoded serial payload bits LSB-first
// into 32-bit words and writes them into the active RX payload buffer bank.
module pyrxaclpack #(
    parameter int MAXBYTE = 1024,
    parameter int ADDRW   = 8
) (
    input  logic             clk_6M,
    input  logic             rstz,
    input  logic             py_start_p,
    input  logic [9:0]       py_lenByte,
    input  logic             rxbit,
    input  logic             rxbit_en,
    input  logic             py_abort_p,
    output logic [ADDRW-1:0] lnctrl_addr,
    output logic [31:0]      lnctrl_din,
    output logic             lnctrl_we,
    output logic             lnctrl_cs,
    output logic             pack_busy,
    output logic             pack_done_p,
    output logic [ADDRW:0]   pack_wordcnt
);

    localparam int LENW = ADDRW + 3;
    localparam int BCW  = ADDRW + 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [LENW-1:0]  len_r;
    logic [BCW-1:0]   bitcnt_r;
    logic [31:0]      sreg_r;
    logic [ADDRW-1:0] addr_r;
    logic [31:0]      din_r;
    logic             we_r;
    logic             busy_r;
    logic             done_r;
    logic [ADDRW:0]   wordcnt_r;

    logic [LENW-1:0]  len_in_s;
    logic [LENW+2:0]  last_full_s;
    logic [BCW-1:0]   last_idx_s;
    logic [4:0]       pos_s;
    logic [31:0]      word_s;
    logic             last_bit_s;
    logic             word_end_s;

    // Clamp the requested payload length to the largest payload the buffer accepts
    always_comb begin
        len_in_s = '0;
        if (int'(py_lenByte) > MAXBYTE) begin
            len_in_s = LENW'(MAXBYTE);
        end else begin
            len_in_s = LENW'(py_lenByte);
        end
    end

    // Index of the final payload bit, current word position and the word as it would close
    always_comb begin
        last_full_s = {len_r, 3'b000} - (LENW+3)'(1);
        last_idx_s  = last_full_s[BCW-1:0];
        pos_s       = bitcnt_r[4:0];
        word_s      = sreg_r;
        word_s[pos_s] = rxbit;
        last_bit_s  = 1'b0;
        word_end_s  = 1'b0;
        if (bitcnt_r == last_idx_s) begin
            last_bit_s = 1'b1;
            word_end_s = 1'b1;
        end else if (pos_s == 5'd31) begin
            word_end_s = 1'b1;
        end else begin
            word_end_s = 1'b0;
        end
    end

    // Packer FSM with registered buffer write port and status outputs
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_r   <= ST_IDLE;
            len_r     <= '0;
            bitcnt_r  <= '0;
            sreg_r    <= 32'd0;
            addr_r    <= '0;
            din_r     <= 32'd0;
            we_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wordcnt_r <= '0;
        end else begin
            we_r   <= 1'b0;
            done_r <= 1'b0;
            if (py_abort_p) begin
                // Abort beats a simultaneous start; written words stay counted
                state_r  <= ST_IDLE;
                busy_r   <= 1'b0;
                bitcnt_r <= '0;
                sreg_r   <= 32'd0;
            end else if (py_start_p) begin
                len_r     <= len_in_s;
                bitcnt_r  <= '0;
                sreg_r    <= 32'd0;
                wordcnt_r <= '0;
                if (len_in_s == '0) begin
                    state_r <= ST_DONE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end else begin
                    state_r <= ST_PACK;
                    busy_r  <= 1'b1;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_PACK: begin
                        if (rxbit_en) begin
                            bitcnt_r <= bitcnt_r + BCW'(1);
                            if (word_end_s) begin
                                sreg_r    <= 32'd0;
                                addr_r    <= bitcnt_r[BCW-1:5];
                                din_r     <= word_s;
                                we_r      <= 1'b1;
                                wordcnt_r <= wordcnt_r + (ADDRW+1)'(1);
                                if (last_bit_s) begin
                                    state_r <= ST_DONE;
                                    busy_r  <= 1'b0;
                                end else begin
                                    state_r <= ST_PACK;
                                end
                            end else begin
                                sreg_r <= word_s;
                            end
                        end else begin
                            state_r <= ST_PACK;
                        end
                    end
                    ST_DONE: begin
                        // Final write is on the port now; completion follows it by one cycle
                        state_r <= ST_IDLE;
                        done_r  <= we_r;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign lnctrl_addr  = addr_r;
    assign lnctrl_din   = din_r;
    assign lnctrl_we    = we_r;
    assign lnctrl_cs    = we_r;
    assign pack_busy    = busy_r;
    assign pack_done_p  = done_r;
    assign pack_wordcnt = wordcnt_r;

endmodule

// File: tb/tb_pyrxaclpack.sv
// Directed bench for pyrxaclpack: a bit-level payload model pushes expected buffer writes
// into a queue, and a write monitor pops and compares them as the packer emits them.
module tb_pyrxaclpack;

    logic        clk_6M = 1'b0;
    logic        rstz = 1'b0;
    logic        py_start_p = 1'b0;
    logic [9:0]  py_lenByte = 10'd0;
    logic        rxbit = 1'b0;
    logic        rxbit_en = 1'b0;
    logic        py_abort_p = 1'b0;
    logic [7:0]  lnctrl_addr;
    logic [31:0] lnctrl_din;
    logic        lnctrl_we;
    logic        lnctrl_cs;
    logic        pack_busy;
    logic        pack_done_p;
    logic [8:0]  pack_wordcnt;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] din;
    } wr_t;

    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          wr_seen = 0;
    int          done_seen = 0;
    int          last_we_cyc = -1;
    int          done_cyc = -1;

    bit          sb_active = 1'b0;
    int          sb_len = 0;
    int          sb_k = 0;
    logic [31:0] sb_word = 32'd0;

    pyrxaclpack dut (
        .clk_6M       (clk_6M),
        .rstz         (rstz),
        .py_start_p   (py_start_p),
        .py_lenByte   (py_lenByte),
        .rxbit        (rxbit),
        .rxbit_en     (rxbit_en),
        .py_abort_p   (py_abort_p),
        .lnctrl_addr  (lnctrl_addr),
        .lnctrl_din   (lnctrl_din),
        .lnctrl_we    (lnctrl_we),
        .lnctrl_cs    (lnctrl_cs),
        .pack_busy    (pack_busy),
        .pack_done_p  (pack_done_p),
        .pack_wordcnt (pack_wordcnt)
    );

    always #83 clk_6M = ~clk_6M;

    always @(posedge clk_6M) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every buffer write must match the oldest expected word
    always @(negedge clk_6M) begin
        if (rstz) begin
            if (lnctrl_we) begin
                wr_t e;
                wr_seen++;
                last_we_cyc = cyc;
                chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
                chk("wr_cs", 64'(lnctrl_cs), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(lnctrl_addr), 64'(e.addr));
                    chk("wr_din", 64'(lnctrl_din), 64'(e.din));
                end
            end
            if (pack_done_p) begin
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic start(input int len);
        py_start_p = 1'b1;
        py_lenByte = 10'(len);
        sb_len     = (len > 1024) ? 1024 : len;
        sb_k       = 0;
        sb_word    = 32'd0;
        sb_active  = (len != 0);
        tick();
        py_start_p = 1'b0;
    endtask

    task automatic abort(input bit with_start, input int len);
        py_abort_p = 1'b1;
        py_start_p = with_start;
        py_lenByte = 10'(len);
        sb_active  = 1'b0;
        tick();
        py_abort_p = 1'b0;
        py_start_p = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        if (sb_active && sb_k < sb_len * 8) begin
            sb_word[sb_k % 32] = b;
            if ((sb_k % 32 == 31) || (sb_k == sb_len * 8 - 1)) begin
                exp_q.push_back({8'(sb_k / 32), sb_word});
                sb_word = 32'd0;
            end
            sb_k++;
            if (sb_k == sb_len * 8) sb_active = 1'b0;
        end
        rxbit    = b;
        rxbit_en = 1'b1;
        tick();
        rxbit_en = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < 8; i++) send_bit(b[i], gap);
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_seen == d0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int d0;
        int w0;
        int s_cyc;
        logic [31:0] v;

        // Reset state
        repeat (2) tick();
        chk("rst_addr", 64'(lnctrl_addr), 64'd0);
        chk("rst_din", 64'(lnctrl_din), 64'd0);
        chk("rst_we_cs", 64'({lnctrl_we, lnctrl_cs}), 64'd0);
        chk("rst_busy_done", 64'({pack_busy, pack_done_p}), 64'd0);
        chk("rst_wordcnt", 64'(pack_wordcnt), 64'd0);
        rstz = 1'b1;
        repeat (2) tick();

        // T1: one word, slow bit rate
        d0 = done_seen; w0 = wr_seen;
        start(4);
        chk("t1_busy", 64'(pack_busy), 64'd1);
        v = 32'hA5C30F01;
        for (int i = 0; i < 32; i++) send_bit(v[i], 5);
        wait_done(d0, 20);
        chk("t1_writes", 64'(wr_seen - w0), 64'd1);
        chk("t1_done", 64'(done_seen - d0), 64'd1);
        chk("t1_done_after_we", 64'(done_cyc), 64'(last_we_cyc + 1));
        chk("t1_wordcnt", 64'(pack_wordcnt), 64'd1);
        chk("t1_busy_low", 64'(pack_busy), 64'd0);

        // T2: partial last word, back-to-back bits
        d0 = done_seen; w0 = wr_seen;
        start(5);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
        send_byte(8'h04, 0); send_byte(8'h7F, 0);
        wait_done(d0, 20);
        chk("t2_writes", 64'(wr_seen - w0), 64'd2);
        chk("t2_done", 64'(done_seen - d0), 64'd1);
        chk("t2_wordcnt", 64'(pack_wordcnt), 64'd2);

        // T3: zero-length payload
        d0 = done_seen; w0 = wr_seen;
        start(0);
        s_cyc = cyc;
        repeat (3) tick();
        chk("t3_done", 64'(done_seen - d0), 64'd1);
        chk("t3_done_cycle", 64'(done_cyc), 64'(s_cyc));
        chk("t3_no_write", 64'(wr_seen - w0), 64'd0);
        chk("t3_wordcnt", 64'(pack_wordcnt), 64'd0);

        // T4: abort after 40 bits of a 10-byte payload
        d0 = done_seen; w0 = wr_seen;
        start(10);
        for (int i = 0; i < 40; i++) send_bit(1'($urandom), 0);
        chk("t4_busy", 64'(pack_busy), 64'd1);
        abort(1'b0, 0);
        rxbit_en = 1'b1;
        repeat (40) tick();
        rxbit_en = 1'b0;
        repeat (3) tick();
        chk("t4_writes", 64'(wr_seen - w0), 64'd1);
        chk("t4_no_done", 64'(done_seen - d0), 64'd0);
        chk("t4_busy_low", 64'(pack_busy), 64'd0);
        chk("t4_wordcnt", 64'(pack_wordcnt), 64'd1);

        // T5: largest length the length port carries, random data
        d0 = done_seen; w0 = wr_seen;
        start(1023);
        for (int i = 0; i < 1023 * 8; i++) send_bit(1'($urandom), 0);
        wait_done(d0, 20);
        chk("t5_writes", 64'(wr_seen - w0), 64'd256);
        chk("t5_done", 64'(done_seen - d0), 64'd1);
        chk("t5_wordcnt", 64'(pack_wordcnt), 64'd256);

        // T6a: restart mid-payload with a new length
        d0 = done_seen; w0 = wr_seen;
        start(8);
        for (int i = 0; i < 20; i++) send_bit(1'($urandom), 0);
        start(4);
        v = 32'h3C96E1D2;
        for (int i = 0; i < 32; i++) send_bit(v[i], 0);
        wait_done(d0, 20);
        chk("t6a_writes", 64'(wr_seen - w0), 64'd1);
        chk("t6a_done", 64'(done_seen - d0), 64'd1);
        chk("t6a_wordcnt", 64'(pack_wordcnt), 64'd1);

        // T6b: abort and start in the same cycle
        d0 = done_seen; w0 = wr_seen;
        start(8);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0);
        abort(1'b1, 4);
        rxbit_en = 1'b1;
        repeat (40) tick();
        rxbit_en = 1'b0;
        repeat (3) tick();
        chk("t6b_busy", 64'(pack_busy), 64'd0);
        chk("t6b_no_write", 64'(wr_seen - w0), 64'd0);
        chk("t6b_no_done", 64'(done_seen - d0), 64'd0);
        chk("t6b_wordcnt", 64'(pack_wordcnt), 64'd0);

        // T6c: asynchronous reset mid-word
        start(8);
        for (int i = 0; i < 40; i++) send_bit(1'b1, 0);
        chk("t6c_busy_pre", 64'(pack_busy), 64'd1);
        chk("t6c_din_pre", 64'(lnctrl_din), 64'hFFFFFFFF);
        #40;
        rstz = 1'b0;
        sb_active = 1'b0;
        #1;
        chk("t6c_rst_addr_din", 64'({lnctrl_addr, lnctrl_din}), 64'd0);
        chk("t6c_rst_ctl", 64'({lnctrl_we, lnctrl_cs, pack_busy, pack_done_p}), 64'd0);
        chk("t6c_rst_wordcnt", 64'(pack_wordcnt), 64'd0);
        tick();
        rstz = 1'b1;
        tick();
        d0 = done_seen; w0 = wr_seen;
        start(2);
        send_byte(8'h5A, 0); send_byte(8'hC3, 0);
        wait_done(d0, 20);
        chk("t6c_post_writes", 64'(wr_seen - w0), 64'd1);
        chk("t6c_post_wordcnt", 64'(pack_wordcnt), 64'd1);

        repeat (2) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
